// File: rtl/star_demux.sv
// star_demux: splits one merged AXI Stream into 4 destination streams, with the
// destination taken from the first beat of each packet. Optional macro: STAR_DEMUX_PKT_CNT_EN.
module star_demux #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SEL_LSB    = 0,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] src_TDATA,
  input  logic                  src_TVALID,
  output logic                  src_TREADY,
  input  logic                  src_TLAST,
  output logic [DATA_WIDTH-1:0] dst0_TDATA,
  output logic                  dst0_TVALID,
  input  logic                  dst0_TREADY,
  output logic                  dst0_TLAST,
  output logic [DATA_WIDTH-1:0] dst1_TDATA,
  output logic                  dst1_TVALID,
  input  logic                  dst1_TREADY,
  output logic                  dst1_TLAST,
  output logic [DATA_WIDTH-1:0] dst2_TDATA,
  output logic                  dst2_TVALID,
  input  logic                  dst2_TREADY,
  output logic                  dst2_TLAST,
  output logic [DATA_WIDTH-1:0] dst3_TDATA,
  output logic                  dst3_TVALID,
  input  logic                  dst3_TREADY,
  output logic                  dst3_TLAST
`ifdef STAR_DEMUX_PKT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  pkt0_cnt,
  output logic [CNT_WIDTH-1:0]  pkt1_cnt,
  output logic [CNT_WIDTH-1:0]  pkt2_cnt,
  output logic [CNT_WIDTH-1:0]  pkt3_cnt
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [1:0]            lock_q, lock_d;
  logic [DATA_WIDTH-1:0] data_q [2];
  logic [DATA_WIDTH-1:0] data_d [2];
  logic                  last_q [2];
  logic                  last_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  src_rdy_q, src_rdy_d;

  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
  logic [1:0]            head_sel;
  logic [1:0]            route;
  logic [3:0]            dst_rdy;
  logic [3:0]            dst_vld;
  logic                  push;
  logic                  pop;

  assign dst_rdy = {dst3_TREADY, dst2_TREADY, dst1_TREADY, dst0_TREADY};

  // Skid buffer: two entries, combinational read of the head entry
  always_comb begin
    head_valid = (occ_q != 2'd0);
    head_data  = data_q[rd_ptr_q];
    head_last  = last_q[rd_ptr_q];
    head_sel   = head_data[SEL_LSB +: 2];
    push       = src_TVALID && src_rdy_q;
    pop        = head_valid && dst_rdy[route];
    data_d     = data_q;
    last_d     = last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      data_d[wr_ptr_q] = src_TDATA;
      last_d[wr_ptr_q] = src_TLAST;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    // ready is registered, so it must already reflect the post-edge occupancy
    src_rdy_d = (occ_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= '0;
      src_rdy_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      last_q    <= last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      src_rdy_q <= src_rdy_d;
    end
  end

  // Route FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // Route FSM: next state
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    unique case (state_q)
      IDLE: begin
        if (pop && !head_last) begin
          state_d = LOCKED;
          lock_d  = head_sel;
        end
      end
      LOCKED: begin
        if (pop && head_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Route FSM: outputs
  always_comb begin
    route   = (state_q == LOCKED) ? lock_q : head_sel;
    dst_vld = '0;
    if (head_valid) begin
      dst_vld[route] = 1'b1;
    end
  end

  always_comb begin
    src_TREADY  = src_rdy_q;
    dst0_TVALID = dst_vld[0];
    dst1_TVALID = dst_vld[1];
    dst2_TVALID = dst_vld[2];
    dst3_TVALID = dst_vld[3];
    dst0_TDATA  = head_valid ? head_data : '0;
    dst1_TDATA  = head_valid ? head_data : '0;
    dst2_TDATA  = head_valid ? head_data : '0;
    dst3_TDATA  = head_valid ? head_data : '0;
    dst0_TLAST  = head_valid && head_last;
    dst1_TLAST  = head_valid && head_last;
    dst2_TLAST  = head_valid && head_last;
    dst3_TLAST  = head_valid && head_last;
  end

`ifdef STAR_DEMUX_PKT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [4];
  logic [CNT_WIDTH-1:0] cnt_d [4];

  always_comb begin
    cnt_d = cnt_q;
    if (pop && head_last) begin
      cnt_d[route] = cnt_q[route] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pkt0_cnt = cnt_q[0];
  assign pkt1_cnt = cnt_q[1];
  assign pkt2_cnt = cnt_q[2];
  assign pkt3_cnt = cnt_q[3];
`endif

endmodule

// File: tb/tb_star_demux.sv
// Self-checking bench for star_demux: packet-level reference model plus directed
// literal checks and randomized traffic.
module tb_star_demux;

  logic       clk;
  logic       rst;
  logic [7:0] src_TDATA;
  logic       src_TVALID;
  logic       src_TREADY;
  logic       src_TLAST;
  logic [7:0] dd [4];
  logic [3:0] dv;
  logic [3:0] drdy;
  logic [3:0] dl;
`ifdef STAR_DEMUX_PKT_CNT_EN
  logic [7:0] pc [4];
`endif

  int checks = 0;
  int errors = 0;

  star_demux #(.DATA_WIDTH(8), .SEL_LSB(0), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .src_TDATA(src_TDATA), .src_TVALID(src_TVALID), .src_TREADY(src_TREADY), .src_TLAST(src_TLAST),
    .dst0_TDATA(dd[0]), .dst0_TVALID(dv[0]), .dst0_TREADY(drdy[0]), .dst0_TLAST(dl[0]),
    .dst1_TDATA(dd[1]), .dst1_TVALID(dv[1]), .dst1_TREADY(drdy[1]), .dst1_TLAST(dl[1]),
    .dst2_TDATA(dd[2]), .dst2_TVALID(dv[2]), .dst2_TREADY(drdy[2]), .dst2_TLAST(dl[2]),
    .dst3_TDATA(dd[3]), .dst3_TVALID(dv[3]), .dst3_TREADY(drdy[3]), .dst3_TLAST(dl[3])
`ifdef STAR_DEMUX_PKT_CNT_EN
    ,
    .pkt0_cnt(pc[0]), .pkt1_cnt(pc[1]), .pkt2_cnt(pc[2]), .pkt3_cnt(pc[3])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a beat's destination is fixed when it is accepted, by packet
  // framing on the source stream; the buffer is just an ordered queue of beats.
  typedef struct {
    logic [1:0] dest;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      mq[$];
  logic       m_rdy = 1'b0;
  logic       m_in_pkt = 1'b0;
  logic [1:0] m_dest = 2'd0;
  logic [7:0] m_cnt [4] = '{default: 8'd0};
  logic [8:0] dlog [4][$];

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_rdy    = 1'b0;
      m_in_pkt = 1'b0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 8'd0;
    end else begin
      logic acc;
      acc = src_TVALID && m_rdy;
      if (mq.size() > 0 && drdy[mq[0].dest]) begin
        if (mq[0].last) m_cnt[mq[0].dest] = m_cnt[mq[0].dest] + 8'd1;
        void'(mq.pop_front());
      end
      if (acc) begin
        beat_t b;
        b.dest   = m_in_pkt ? m_dest : src_TDATA[1:0];
        b.data   = src_TDATA;
        b.last   = src_TLAST;
        m_dest   = b.dest;
        m_in_pkt = !src_TLAST;
        mq.push_back(b);
      end
      m_rdy = (mq.size() < 2);
    end
  end

  // Compare process: outputs are stable between edges, so check at negedge
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_src_tready", {31'd0, src_TREADY}, 32'd0);
      chk("rst_dst_tvalid", {28'd0, dv}, 32'd0);
      chk("rst_dst_tlast", {28'd0, dl}, 32'd0);
      for (int k = 0; k < 4; k++) chk("rst_dst_tdata", {24'd0, dd[k]}, 32'd0);
    end else begin
      chk("src_tready", {31'd0, src_TREADY}, {31'd0, m_rdy});
      for (int k = 0; k < 4; k++) begin
        logic ev;
        ev = (mq.size() > 0) && (mq[0].dest == k[1:0]);
        chk("dst_tvalid", {31'd0, dv[k]}, {31'd0, ev});
        if (mq.size() > 0) begin
          chk("dst_tdata", {24'd0, dd[k]}, {24'd0, mq[0].data});
          chk("dst_tlast", {31'd0, dl[k]}, {31'd0, mq[0].last});
        end
        if (dv[k] && drdy[k]) dlog[k].push_back({dl[k], dd[k]});
`ifdef STAR_DEMUX_PKT_CNT_EN
        chk("pkt_cnt", {24'd0, pc[k]}, {24'd0, m_cnt[k]});
`endif
      end
    end
  end

  task automatic clear_logs();
    for (int k = 0; k < 4; k++) dlog[k].delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    src_TDATA  = d;
    src_TLAST  = l;
    src_TVALID = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!src_TREADY && n < 300);
    if (!src_TREADY) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    src_TVALID = 1'b0;
    src_TLAST  = 1'b0;
  endtask

  task automatic chk_log(input string name, input int k, input logic [8:0] exp [$]);
    chk({name, "_len"}, dlog[k].size(), exp.size());
    for (int i = 0; i < exp.size() && i < dlog[k].size(); i++)
      chk({name, "_beat"}, {23'd0, dlog[k][i]}, {23'd0, exp[i]});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    src_TVALID = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    src_TDATA  = 8'h00;
    src_TLAST  = 1'b0;
    src_TVALID = 1'b1;
    drdy       = 4'b0000;

    // Reset held with valid asserted
    repeat (3) @(posedge clk);
    #1;
    chk("t1_rdy_in_rst", {31'd0, src_TREADY}, 32'd0);
    chk("t1_vld_in_rst", {28'd0, dv}, 32'd0);
    rst        = 1'b1;
    src_TVALID = 1'b0;
    cycles(1);
    chk("t1_rdy_after_rst", {31'd0, src_TREADY}, 32'd1);

    // Streaming to dst1
    clear_logs();
    drdy = 4'b0010;
    send(8'h01, 1'b0);
    send(8'h05, 1'b0);
    send(8'h09, 1'b1);
    cycles(4);
    chk_log("t2_dst1", 1, '{9'h001, 9'h005, 9'h109});
    chk("t2_others", dlog[0].size() + dlog[2].size() + dlog[3].size(), 32'd0);

    // Lock holds across a beat whose select bits say dst3
    clear_logs();
    drdy = 4'b1100;
    send(8'h02, 1'b0);
    send(8'h07, 1'b1);
    send(8'h03, 1'b1);
    cycles(4);
    chk_log("t3_dst2", 2, '{9'h002, 9'h107});
    chk_log("t3_dst3", 3, '{9'h103});

    // Backpressure: fill the buffer, then release
    clear_logs();
    drdy = 4'b0000;
    fork
      begin
        send(8'h00, 1'b0);
        send(8'h04, 1'b0);
        send(8'h08, 1'b0);
        send(8'h0C, 1'b1);
      end
      begin
        repeat (6) @(negedge clk);
        chk("t4_rdy_full", {31'd0, src_TREADY}, 32'd0);
        chk("t4_no_delivery", dlog[0].size(), 32'd0);
        @(posedge clk);
        #1;
        drdy = 4'b0001;
      end
    join
    cycles(4);
    chk_log("t4_dst0", 0, '{9'h000, 9'h004, 9'h008, 9'h10C});

    // Reset mid-packet discards the buffered beat and the lock
    clear_logs();
    drdy = 4'b0100;
    send(8'h01, 1'b0);
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(1);
    drdy = 4'b0110;
    send(8'h02, 1'b1);
    cycles(4);
    chk_log("t5_dst2", 2, '{9'h102});
    chk("t5_dst1_empty", dlog[1].size(), 32'd0);

    // 300 one-beat packets to dst0
    do_reset();
    clear_logs();
    drdy = 4'b1111;
    for (int i = 0; i < 300; i++) send(8'h00, 1'b1);
    cycles(4);
    chk("t6_dst0_beats", dlog[0].size(), 32'd300);
`ifdef STAR_DEMUX_PKT_CNT_EN
    chk("t6_pkt0_cnt", {24'd0, pc[0]}, 32'd44);
    chk("t6_pkt_other", {24'd0, pc[1] | pc[2] | pc[3]}, 32'd0);
`endif

    // Random traffic
    begin
      int sent, cyc;
      logic acc;
      sent = 0;
      cyc  = 0;
      acc  = 1'b0;
      src_TVALID = 1'b0;
      while (sent < 10000 && cyc < 60000) begin
        if (acc) sent++;
        if (!src_TVALID || acc) begin
          src_TVALID = ($urandom_range(3) != 0);
          src_TDATA  = 8'($urandom_range(255));
          src_TLAST  = ($urandom_range(3) == 0);
        end
        for (int k = 0; k < 4; k++) drdy[k] = ($urandom_range(3) != 0);
        @(negedge clk);
        acc = src_TVALID && src_TREADY;
        cyc++;
        @(posedge clk);
        #1;
      end
      if (acc) sent++;
      chk("rand_beats_sent", (sent >= 10000) ? 32'd1 : 32'd0, 32'd1);
      src_TVALID = 1'b0;
      drdy = 4'b1111;
      cycles(6);
      chk("rand_drained", {31'd0, |dv}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
